// File: rtl/udp_stream_pkg.sv
// Shared types and defaults for the UDP video transmit controller.
// Imported by the top and the per-channel sync block.
package udp_stream_pkg;

  typedef enum logic [3:0] {
    IDLE,
    ARP_REQ,
    ARP_SEND,
    ARP_WAIT,
    WAIT_SYNC,
    ARBITRATE,
    GEN_REQ,
    SEND,
    CHECK_ARP,
    ARP_FAIL
  } state_t;

  localparam int DEF_INIT_WAIT    = 1_250_000;
  localparam int DEF_ARP_TIMEOUT  = 125_000_000;
  localparam int DEF_ARP_RETRY    = 8;
  localparam int DEF_FIFO_TIMEOUT = 125_000_000;
  localparam int DEF_SYNC_DLY     = 10;

  function automatic int ch_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/udp_ch_sync.sv
// Per-channel vsync/href synchroniser, delayed arm flag and line counter.
// One instance per camera channel.
module udp_ch_sync
  import udp_stream_pkg::*;
#(
  parameter int SYNC_DLY = DEF_SYNC_DLY,
  parameter int LC_W     = 15
) (
  input  logic            gmii_tx_clk,
  input  logic            rst_n,
  input  logic            vsync,
  input  logic            href,
  input  logic            disarm,
  output logic            armed,
  output logic [LC_W-1:0] line_count
);

  logic [2:0]          vs_s;
  logic [2:0]          hr_s;
  logic [SYNC_DLY-1:0] dly;
  logic                vs_rise;
  logic                hr_rise;

  assign vs_rise = vs_s[1] & ~vs_s[2];
  assign hr_rise = hr_s[1] & ~hr_s[2];

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_s <= '0;
      hr_s <= '0;
      dly  <= '0;
    end else begin
      vs_s <= {vs_s[1:0], vsync};
      hr_s <= {hr_s[1:0], href};
      dly  <= (dly << 1) | SYNC_DLY'(vs_rise);
    end
  end

  // A fresh frame start re-arms even if a disarm lands in the same cycle
  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
    end else if (dly[SYNC_DLY-1]) begin
      armed <= 1'b1;
    end else if (disarm) begin
      armed <= 1'b0;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      line_count <= '0;
    end else if (vs_rise) begin
      line_count <= '0;
    end else if (hr_rise) begin
      line_count <= line_count + 1'b1;
    end
  end

endmodule

// File: rtl/udp_stream_ctrl.sv
// Multi-channel UDP video transmit controller in front of mac_top.
// ARP bring-up, frame-sync arming and round-robin packet scheduling.
module udp_stream_ctrl
  import udp_stream_pkg::*;
#(
  parameter int NUM_CH        = 2,
  parameter int CNT_W         = 11,
  parameter int PKT_BYTES     = 1200,
  parameter int INIT_WAIT     = DEF_INIT_WAIT,
  parameter int ARP_TIMEOUT   = DEF_ARP_TIMEOUT,
  parameter int ARP_RETRY_MAX = DEF_ARP_RETRY,
  parameter int FIFO_TIMEOUT  = DEF_FIFO_TIMEOUT,
  parameter int SYNC_DLY      = DEF_SYNC_DLY,
  localparam int CH_W         = ch_w(NUM_CH)
) (
  input  logic                    gmii_tx_clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [NUM_CH-1:0]       cmos_vsync,
  input  logic [NUM_CH-1:0]       cmos_href,
  input  logic [NUM_CH*CNT_W-1:0] fifo_count,
  input  logic [NUM_CH*8-1:0]     fifo_data,
  output logic [NUM_CH-1:0]       fifo_rd_en,
  input  logic                    mac_fifo_rd_en,
  output logic [7:0]              mac_fifo_data,
  input  logic                    mac_send_end,
  input  logic                    arp_found,
  input  logic                    mac_not_exist,
  output logic                    udp_tx_req,
  output logic                    arp_request_req,
  output logic [15:0]             udp_send_data_length,
  output logic [15:0]             identify_code,
  output logic [CH_W-1:0]         ch_sel,
  output logic                    arp_fail
);

  localparam int LC_W = 16 - CH_W;

  state_t            state;
  state_t            state_nxt;
  logic [31:0]       wait_cnt;
  logic [7:0]        retry_cnt;
  logic [CH_W-1:0]   last_ch;
  logic [CH_W-1:0]   rr_sel;
  logic              rr_found;
  logic [NUM_CH-1:0] armed;
  logic [NUM_CH-1:0] elig;
  logic              disarm_all;
  logic              retry_inc;
  logic              retry_clr;
  logic              cnt_run;
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [LC_W-1:0]   line_cnt [NUM_CH];

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    udp_ch_sync #(
      .SYNC_DLY (SYNC_DLY),
      .LC_W     (LC_W)
    ) u_sync (
      .gmii_tx_clk (gmii_tx_clk),
      .rst_n       (rst_n),
      .vsync       (cmos_vsync[g]),
      .href        (cmos_href[g]),
      .disarm      (disarm_all),
      .armed       (armed[g]),
      .line_count  (line_cnt[g])
    );

    always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q[g] <= '0;
      end else begin
        cnt_q[g] <= fifo_count[g*CNT_W +: CNT_W];
      end
    end

    assign elig[g] = armed[g] && (32'(cnt_q[g]) >= 32'(PKT_BYTES));
  end

  // Search begins one past the last served channel
  always_comb begin
    int idx;
    idx      = 0;
    rr_found = 1'b0;
    rr_sel   = '0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = (int'(last_ch) + k) % NUM_CH;
      if (!rr_found && elig[idx]) begin
        rr_found = 1'b1;
        rr_sel   = CH_W'(idx);
      end
    end
  end

  always_comb begin
    state_nxt  = state;
    disarm_all = 1'b0;
    retry_inc  = 1'b0;
    retry_clr  = 1'b0;
    if (!enable) begin
      state_nxt = IDLE;
      retry_clr = 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          if (wait_cnt == 32'(INIT_WAIT)) state_nxt = ARP_REQ;
        end
        ARP_REQ: state_nxt = ARP_SEND;
        ARP_SEND: begin
          if (mac_send_end) state_nxt = ARP_WAIT;
        end
        ARP_WAIT: begin
          if (arp_found) begin
            state_nxt = WAIT_SYNC;
            retry_clr = 1'b1;
          end else if (wait_cnt == 32'(ARP_TIMEOUT)) begin
            retry_inc = 1'b1;
            if (retry_cnt + 8'd1 == 8'(ARP_RETRY_MAX)) begin
              state_nxt = ARP_FAIL;
            end else begin
              state_nxt = ARP_REQ;
            end
          end
        end
        WAIT_SYNC: begin
          if (|armed) state_nxt = ARBITRATE;
        end
        ARBITRATE: begin
          if (rr_found) begin
            state_nxt = GEN_REQ;
          end else if (wait_cnt == 32'(FIFO_TIMEOUT)) begin
            disarm_all = 1'b1;
            state_nxt  = WAIT_SYNC;
          end
        end
        GEN_REQ: state_nxt = SEND;
        SEND: begin
          if (mac_send_end) state_nxt = CHECK_ARP;
        end
        CHECK_ARP: begin
          state_nxt = mac_not_exist ? ARP_REQ : ARBITRATE;
        end
        ARP_FAIL: state_nxt = ARP_FAIL;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Held at zero while disabled so IDLE cannot overshoot the power-up wait
  assign cnt_run = enable &&
                   (state == IDLE || state == ARP_WAIT ||
                    state == ARBITRATE);

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !cnt_run) begin
        wait_cnt <= '0;
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      retry_cnt <= '0;
    end else if (retry_clr) begin
      retry_cnt <= '0;
    end else if (retry_inc) begin
      retry_cnt <= retry_cnt + 8'd1;
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_sel        <= '0;
      last_ch       <= CH_W'(NUM_CH - 1);
      identify_code <= '0;
    end else begin
      if (state == ARBITRATE && rr_found) ch_sel <= rr_sel;
      if (state == SEND && mac_send_end) last_ch <= ch_sel;
      if (state == GEN_REQ) begin
        identify_code <= {ch_sel, line_cnt[ch_sel]};
      end
    end
  end

  always_ff @(posedge gmii_tx_clk or negedge rst_n) begin
    if (!rst_n) begin
      fifo_rd_en <= '0;
    end else if (mac_fifo_rd_en) begin
      fifo_rd_en <= NUM_CH'(1) << ch_sel;
    end else begin
      fifo_rd_en <= '0;
    end
  end

  always_comb begin
    mac_fifo_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == ch_sel) mac_fifo_data = fifo_data[i*8 +: 8];
    end
  end

  assign udp_tx_req           = (state == GEN_REQ);
  assign arp_request_req      = (state == ARP_REQ);
  assign arp_fail             = (state == ARP_FAIL);
  assign udp_send_data_length = 16'(PKT_BYTES);

endmodule
